// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: redirect-select encodings,
// fetch FSM states and the default boot address.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'd0,
        PCSRC_BR  = 2'd1,
        PCSRC_JR  = 2'd2,
        PCSRC_J   = 2'd3
    } pcsrc_e;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          AW_DEFAULT       = 32;

endpackage

// File: rtl/fetch_sequencer_next_pc_sel.sv
// Redirect target mux: picks branch, register or J-format target from PCSrc.
// Kept standalone so a branch target buffer can reuse the same selection.
module next_pc_sel
    import fetch_sequencer_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic [1:0]    pc_src,
    input  logic [AW-1:0] branch_target,
    input  logic [AW-1:0] jr_target,
    input  logic [25:0]   jump_index,
    input  logic [AW-1:0] pc_plus4,
    output logic [AW-1:0] target
);

    always_comb begin
        target = pc_plus4;
        case (pcsrc_e'(pc_src))
            PCSRC_BR: target = branch_target;
            PCSRC_JR: target = jr_target;
            // J-format keeps the 256 MB region of the delay-slot-free PC+4
            PCSRC_J:  target = {pc_plus4[AW-1:28], jump_index, 2'b00};
            default:  target = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC, instruction-memory handshake and IF/ID register.
// Optional FETCH_STATS_EN adds saturating redirect/discard counters.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          AW       = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    PCSrc,
    input  logic [31:0]   branch_target,
    input  logic [31:0]   jr_target,
    input  logic [25:0]   jump_index,
    input  logic          StallD,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic [31:0]   instr_d,
    output logic [AW-1:0] pc_plus4_d,
    output logic          valid_d,
    output logic          StallF,
    output logic          FlushD
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]   redirect_cnt,
    output logic [31:0]   discard_cnt
`endif
);

    localparam logic [AW-1:0] RESET_ADDR = RESET_PC[AW-1:0];
    localparam logic [AW-1:0] PC_STEP    = AW'(4);

    fetch_state_e  state_reg, state_next;
    logic [AW-1:0] pc_f_reg, pc_f_next;
    logic [AW-1:0] redir_pc_reg, redir_pc_next;
    logic [31:0]   hold_reg, hold_next;
    logic [31:0]   instr_d_reg, instr_d_next;
    logic [AW-1:0] pc_plus4_d_reg, pc_plus4_d_next;
    logic          valid_d_reg, valid_d_next;
    logic          redirect;
    logic [AW-1:0] target;

    next_pc_sel #(.AW(AW)) u_next_pc_sel (
        .pc_src        (PCSrc),
        .branch_target (branch_target[AW-1:0]),
        .jr_target     (jr_target[AW-1:0]),
        .jump_index    (jump_index),
        .pc_plus4      (pc_plus4_d_reg),
        .target        (target)
    );

    // Only a live, non-stalled ID instruction may steer fetch
    assign redirect = valid_d_reg & ~StallD & (PCSrc != PCSRC_SEQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_BOOT;
            pc_f_reg       <= RESET_ADDR;
            redir_pc_reg   <= '0;
            hold_reg       <= '0;
            instr_d_reg    <= '0;
            pc_plus4_d_reg <= '0;
            valid_d_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_f_reg       <= pc_f_next;
            redir_pc_reg   <= redir_pc_next;
            hold_reg       <= hold_next;
            instr_d_reg    <= instr_d_next;
            pc_plus4_d_reg <= pc_plus4_d_next;
            valid_d_reg    <= valid_d_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_f_next       = pc_f_reg;
        redir_pc_next   = redir_pc_reg;
        hold_next       = hold_reg;
        instr_d_next    = instr_d_reg;
        pc_plus4_d_next = pc_plus4_d_reg;
        valid_d_next    = valid_d_reg;

        case (state_reg)
            S_BOOT: begin
                state_next = S_REQ;
            end

            S_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_f_next    = target;
                        valid_d_next = 1'b0;
                    end else if (StallD) begin
                        // ID cannot take the word yet: park it and stop requesting
                        hold_next  = imem_rdata;
                        pc_f_next  = pc_f_reg + PC_STEP;
                        state_next = S_HOLD;
                    end else begin
                        instr_d_next    = imem_rdata;
                        pc_plus4_d_next = pc_f_reg + PC_STEP;
                        valid_d_next    = 1'b1;
                        pc_f_next       = pc_f_reg + PC_STEP;
                    end
                end else if (redirect) begin
                    // Address must stay stable until the in-flight request completes
                    redir_pc_next = target;
                    valid_d_next  = 1'b0;
                    state_next    = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (imem_ack) begin
                    pc_f_next  = redir_pc_reg;
                    state_next = S_REQ;
                end
            end

            S_HOLD: begin
                if (!StallD) begin
                    if (redirect) begin
                        pc_f_next    = target;
                        valid_d_next = 1'b0;
                    end else begin
                        // pc_f already advanced past the held word, so it is its PC+4
                        instr_d_next    = hold_reg;
                        pc_plus4_d_next = pc_f_reg;
                        valid_d_next    = 1'b1;
                    end
                    state_next = S_REQ;
                end
            end

            default: begin
                state_next = S_BOOT;
            end
        endcase
    end

    assign imem_req   = (state_reg == S_REQ) || (state_reg == S_DRAIN);
    assign imem_addr  = pc_f_reg;
    assign instr_d    = instr_d_reg;
    assign pc_plus4_d = pc_plus4_d_reg;
    assign valid_d    = valid_d_reg;
    assign StallF     = StallD;
    assign FlushD     = redirect;

`ifdef FETCH_STATS_EN
    logic       discard;
    logic [1:0] cnt_inc;

    // Every wrong-path word is dropped exactly once: at a redirecting ack,
    // at the draining ack, or when a parked word is abandoned
    assign discard = ((state_reg == S_REQ)   & imem_ack & redirect) |
                     ((state_reg == S_DRAIN) & imem_ack)            |
                     ((state_reg == S_HOLD)  & ~StallD  & redirect);
    assign cnt_inc = {discard, redirect};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [31:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign redirect_cnt = g_cnt[0].cnt_reg;
    assign discard_cnt  = g_cnt[1].cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  PCSrc;
    logic [31:0] branch_target;
    logic [31:0] jr_target;
    logic [25:0] jump_index;
    logic        StallD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        StallF;
    logic        FlushD;
`ifdef FETCH_STATS_EN
    logic [31:0] redirect_cnt;
    logic [31:0] discard_cnt;
`endif

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .AW(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .jr_target     (jr_target),
        .jump_index    (jump_index),
        .StallD        (StallD),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_d       (instr_d),
        .pc_plus4_d    (pc_plus4_d),
        .valid_d       (valid_d),
        .StallF        (StallF),
        .FlushD        (FlushD)
`ifdef FETCH_STATS_EN
        ,
        .redirect_cnt  (redirect_cnt),
        .discard_cnt   (discard_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch pipeline described as boot flag, pending
    // wrong-path request, and a queue of words parked behind a stall
    bit          m_boot;
    bit          m_drain;
    logic [31:0] m_pc;
    logic [31:0] m_drain_tgt;
    logic [31:0] m_instr;
    logic [31:0] m_pp4;
    bit          m_valid;
    logic [31:0] held_q[$];
    logic [31:0] m_redir_cnt;
    logic [31:0] m_disc_cnt;

    task automatic model_reset();
        m_boot      = 1'b1;
        m_drain     = 1'b0;
        m_pc        = 32'h0;
        m_drain_tgt = 32'h0;
        m_instr     = 32'h0;
        m_pp4       = 32'h0;
        m_valid     = 1'b0;
        held_q.delete();
        m_redir_cnt = 32'h0;
        m_disc_cnt  = 32'h0;
    endtask

    function automatic bit m_req();
        return !m_boot && (held_q.size() == 0);
    endfunction

    function automatic logic [31:0] m_target();
        case (PCSrc)
            2'd1:    return branch_target;
            2'd2:    return jr_target;
            2'd3:    return (m_pp4 & 32'hF000_0000) | (32'(jump_index) << 2);
            default: return m_pp4;
        endcase
    endfunction

    function automatic bit m_flush();
        return m_valid && !StallD && (PCSrc != 2'd0);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic check_model();
        bit er;
        er = m_req();
        check("imem_req", 32'(imem_req), 32'(er));
        if (er) check("imem_addr", imem_addr, m_pc);
        check("FlushD", 32'(FlushD), 32'(m_flush()));
        check("StallF", 32'(StallF), 32'(StallD));
        check("valid_d", 32'(valid_d), 32'(m_valid));
        check("instr_d", instr_d, m_instr);
        check("pc_plus4_d", pc_plus4_d, m_pp4);
`ifdef FETCH_STATS_EN
        check("redirect_cnt", redirect_cnt, m_redir_cnt);
        check("discard_cnt", discard_cnt, m_disc_cnt);
`endif
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        logic [31:0] w;
        bit          fl;
        tgt = m_target();
        fl  = m_flush();
        if (fl) m_redir_cnt = sat_inc(m_redir_cnt);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (held_q.size() != 0) begin
            if (!StallD) begin
                w = held_q.pop_front();
                if (fl) begin
                    m_pc       = tgt;
                    m_valid    = 1'b0;
                    m_disc_cnt = sat_inc(m_disc_cnt);
                end else begin
                    m_instr = w;
                    m_pp4   = m_pc;
                    m_valid = 1'b1;
                end
            end
        end else if (m_drain) begin
            if (imem_ack) begin
                m_pc       = m_drain_tgt;
                m_drain    = 1'b0;
                m_disc_cnt = sat_inc(m_disc_cnt);
            end
        end else if (imem_ack) begin
            if (fl) begin
                m_pc       = tgt;
                m_valid    = 1'b0;
                m_disc_cnt = sat_inc(m_disc_cnt);
            end else if (StallD) begin
                held_q.push_back(mem_word(m_pc));
                m_pc = m_pc + 32'd4;
            end else begin
                m_instr = mem_word(m_pc);
                m_pp4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end else if (fl) begin
            m_drain     = 1'b1;
            m_drain_tgt = tgt;
            m_valid     = 1'b0;
        end
    endtask

    task automatic cycle(input logic [1:0] src, input logic [31:0] bt, input logic [31:0] jt,
                         input logic [25:0] ji, input logic st, input logic ak);
        @(negedge clk);
        PCSrc         = src;
        branch_target = bt;
        jr_target     = jt;
        jump_index    = ji;
        StallD        = st;
        imem_ack      = ak;
        #1;
        check_model();
        model_step();
    endtask

    typedef struct {
        logic [1:0]  src;
        logic [31:0] bt;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_flush;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pp4;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] r;
        logic [1:0]  rs;

        vecs[0] = '{2'd0, 32'h0,   1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 32'h0,             32'h000};
        vecs[1] = '{2'd0, 32'h0,   1'b1, 1'b1, 32'h000, 1'b0, 1'b0, 32'h0,             32'h000};
        vecs[2] = '{2'd0, 32'h0,   1'b1, 1'b1, 32'h004, 1'b0, 1'b1, mem_word(32'h000), 32'h004};
        vecs[3] = '{2'd1, 32'h100, 1'b1, 1'b1, 32'h008, 1'b1, 1'b1, mem_word(32'h004), 32'h008};
        vecs[4] = '{2'd0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 1'b0, mem_word(32'h004), 32'h008};
        vecs[5] = '{2'd0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 1'b1, mem_word(32'h100), 32'h104};
        vecs[6] = '{2'd0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b0, 1'b1, mem_word(32'h104), 32'h108};

        rst_n = 1'b0;
        PCSrc = 2'd0; branch_target = 32'h0; jr_target = 32'h0;
        jump_index = 26'h0; StallD = 1'b0; imem_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_model();
        check("reset_addr", imem_addr, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Boot, sequential fetch and a branch taken with an ack in the same cycle
        foreach (vecs[i]) begin
            cycle(vecs[i].src, vecs[i].bt, vecs[i].bt, 26'h0, 1'b0, vecs[i].ack);
            check("vec_req", 32'(imem_req), 32'(vecs[i].exp_req));
            check("vec_addr", imem_addr, vecs[i].exp_addr);
            check("vec_flush", 32'(FlushD), 32'(vecs[i].exp_flush));
            check("vec_valid", 32'(valid_d), 32'(vecs[i].exp_valid));
            check("vec_instr", instr_d, vecs[i].exp_instr);
            check("vec_pp4", pc_plus4_d, vecs[i].exp_pp4);
        end

        // Redirect to 0x200 while the fetch of 0x10C waits three cycles for ack
        cycle(2'd1, 32'h200, 32'h0, 26'h0, 1'b0, 1'b0);
        check("drain_flush", 32'(FlushD), 32'h1);
        cycle(2'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0);
        check("drain_addr_hold", imem_addr, 32'h10C);
        cycle(2'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0);
        check("drain_addr_hold", imem_addr, 32'h10C);
        cycle(2'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b1);
        check("drain_addr_ack", imem_addr, 32'h10C);
        cycle(2'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b1);
        check("drain_new_addr", imem_addr, 32'h200);
        check("drain_no_wrong_path", 32'(valid_d), 32'h0);

        // Four-cycle stall arriving with an ack: word parked, request dropped
        cycle(2'd0, 32'h0, 32'h0, 26'h0, 1'b1, 1'b1);
        check("stall_instr", instr_d, mem_word(32'h200));
        for (int k = 0; k < 3; k++) begin
            cycle(2'd0, 32'h0, 32'h0, 26'h0, 1'b1, 1'b0);
            check("hold_req", 32'(imem_req), 32'h0);
            check("hold_instr_frozen", instr_d, mem_word(32'h200));
        end
        cycle(2'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0);
        check("hold_release_req", 32'(imem_req), 32'h0);

        // Held word delivered, then jr to 0x1000_0000 and a J-format jump
        cycle(2'd2, 32'h0, 32'h1000_0000, 26'h0, 1'b0, 1'b1);
        check("held_instr", instr_d, mem_word(32'h204));
        check("held_pp4", pc_plus4_d, 32'h208);
        check("jr_flush", 32'(FlushD), 32'h1);
        cycle(2'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b1);
        check("jr_addr", imem_addr, 32'h1000_0000);
        cycle(2'd3, 32'h0, 32'h0, 26'h000_0040, 1'b0, 1'b1);
        check("j_pp4", pc_plus4_d, 32'h1000_0004);
        check("j_flush", 32'(FlushD), 32'h1);
        cycle(2'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b1);
        check("j_addr", imem_addr, 32'h1000_0100);

        // jr to the top word, then sequential fetch wraps to address zero
        cycle(2'd2, 32'h0, 32'hFFFF_FFFC, 26'h0, 1'b0, 1'b1);
        check("wrap_flush", 32'(FlushD), 32'h1);
        cycle(2'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b1);
        check("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        cycle(2'd0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b1);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pp4", pc_plus4_d, 32'h0);
        check("wrap_instr", instr_d, mem_word(32'hFFFF_FFFC));
`ifdef FETCH_STATS_EN
        check("stats_redirects", redirect_cnt, 32'd5);
        check("stats_discards", discard_cnt, 32'd5);
`endif

        // Randomized traffic, with one reset dropped into the middle
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom;
            rs = ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : 2'd0;
            cycle(rs,
                  r & 32'hFFFF_FFFC,
                  ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                  26'($urandom),
                  ($urandom_range(3) == 0),
                  m_req() && ($urandom_range(2) != 0));
            if (i == 1500) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_model();
                check("midreset_addr", imem_addr, 32'h0);
                @(posedge clk);
                #2 rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
